pipe_stall_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage core. It merges the load-use hazard request, taken-branch flush, multi-cycle data-memory wait and debug halt/resume into one consistent set of enable, bubble and flush controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It also counts stall and flush events for performance statistics. It sits beside the hazard/forwarding unit, which keeps producing mux selects, and owns every pipeline-register enable.

---
 rtl/pipe_ctrl_pkg.sv | 16 +
 rtl/sat_counter.sv | 21 ++
 rtl/pipe_stall_ctrl.sv | 154 +++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } state_t;

   // Active-low nop controls: 0 injects a nop, 1 passes the instruction.
   localparam logic NOP_ON_S  = 1'b0;
   localparam logic NOP_OFF_S = 1'b1;

   localparam int unsigned DRAIN_CYCLES_DEF = 3;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear.
module sat_counter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] count
);

   // Clear beats increment; the count sticks at all-ones.
   always_ff @(posedge clk) begin
      if (!reset_n || clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline sequencing controller: merges load-use, branch flush, memory
// wait and debug halt into the pipeline-register enable/bubble/flush set.
module pipe_stall_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W        = 16,
   parameter int unsigned MEM_TIMEOUT  = 15,
   parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             ld_hazard,
   input  logic             br_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   input  logic             halt_req,
   input  logic             resume,
   input  logic             clr_stats,
   output logic             pc_enable,
   output logic             ifid_enable,
   output logic             ifid_flush,
   output logic             nop_insertion_s,
   output logic             idex_enable,
   output logic             exmem_enable,
   output logic             memwb_nop_s,
   output logic             halted,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
   localparam int unsigned DCNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   state_t              state, state_nxt;
   logic [DCNT_W-1:0]   dcnt, dcnt_nxt;
   logic [WAIT_W-1:0]   wait_cnt, wait_nxt;
   logic                halt_blk, halt_blk_nxt;
   logic                freeze;
   logic                stall_inc;

   assign freeze = mem_req & ~mem_ready;

   // Next state and Mealy control outputs; freeze overrides every state.
   always_comb begin
      state_nxt       = state;
      dcnt_nxt        = dcnt;
      halt_blk_nxt    = halt_blk & halt_req;
      stall_inc       = 1'b0;
      pc_enable       = 1'b1;
      ifid_enable     = 1'b1;
      ifid_flush      = 1'b0;
      nop_insertion_s = NOP_OFF_S;
      idex_enable     = 1'b1;
      exmem_enable    = 1'b1;
      memwb_nop_s     = NOP_OFF_S;

      if (!reset_n) begin
         state_nxt = RUN;
      end else if (freeze) begin
         pc_enable    = 1'b0;
         ifid_enable  = 1'b0;
         idex_enable  = 1'b0;
         exmem_enable = 1'b0;
         memwb_nop_s  = NOP_ON_S;
         stall_inc    = 1'b1;
      end else begin
         case (state)
            RUN: begin
               if (ld_hazard) begin
                  pc_enable       = 1'b0;
                  ifid_enable     = 1'b0;
                  nop_insertion_s = NOP_ON_S;
                  stall_inc       = 1'b1;
               end else if (br_taken) begin
                  ifid_flush = 1'b1;
               end else if (halt_req && !halt_blk) begin
                  state_nxt = DRAIN;
                  dcnt_nxt  = '0;
               end
            end
            DRAIN: begin
               pc_enable       = 1'b0;
               ifid_enable     = 1'b0;
               nop_insertion_s = NOP_ON_S;
               if (dcnt == DCNT_W'(DRAIN_CYCLES - 1)) begin
                  state_nxt = HALTED;
               end else begin
                  dcnt_nxt = dcnt + DCNT_W'(1);
               end
            end
            HALTED: begin
               pc_enable       = 1'b0;
               ifid_enable     = 1'b0;
               nop_insertion_s = NOP_ON_S;
               if (resume) begin
                  state_nxt    = RUN;
                  // A halt_req still held at resume must drop before it counts again.
                  halt_blk_nxt = halt_req;
               end
            end
            default: begin
               state_nxt = RUN;
            end
         endcase
      end
   end

   // Consecutive memory-wait cycles, saturating at the timeout threshold.
   always_comb begin
      wait_nxt = '0;
      if (freeze) begin
         wait_nxt = (wait_cnt == WAIT_W'(MEM_TIMEOUT)) ? wait_cnt : wait_cnt + WAIT_W'(1);
      end
   end

   // State, drain/wait counters and registered status flags.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= RUN;
         dcnt        <= '0;
         wait_cnt    <= '0;
         halt_blk    <= 1'b0;
         halted      <= 1'b0;
         mem_timeout <= 1'b0;
      end else begin
         state    <= state_nxt;
         dcnt     <= dcnt_nxt;
         wait_cnt <= wait_nxt;
         halt_blk <= halt_blk_nxt;
         halted   <= (state_nxt == HALTED);
         if (wait_nxt == WAIT_W'(MEM_TIMEOUT)) begin
            mem_timeout <= 1'b1;
         end
      end
   end

   sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (stall_inc),
      .clr     (clr_stats),
      .count   (stall_cnt)
   );

   sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (ifid_flush),
      .clr     (clr_stats),
      .count   (flush_cnt)
   );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: vector table plus hand sequences.
module tb_pipe_stall_ctrl;

   // out = {pc, ifid, flush, nop_s, idex, exmem, memwb_s, halted, timeout}
   localparam logic [8:0] RUNP = 9'b110111100;
   localparam logic [8:0] LDP  = 9'b000011100;
   localparam logic [8:0] BRP  = 9'b111111100;
   localparam logic [8:0] FRZ  = 9'b000100000;
   localparam logic [8:0] DRN  = 9'b000011100;
   localparam logic [8:0] HLT  = 9'b000011110;
   localparam logic [8:0] TO   = 9'b000000001;

   // in = {ld, br, mreq, mrdy, halt, resume, clr}
   localparam logic [6:0] I_NONE = 7'b0000000;
   localparam logic [6:0] I_LD   = 7'b1000000;
   localparam logic [6:0] I_BR   = 7'b0100000;
   localparam logic [6:0] I_MREQ = 7'b0010000;
   localparam logic [6:0] I_MRDY = 7'b0001000;
   localparam logic [6:0] I_HALT = 7'b0000100;
   localparam logic [6:0] I_RES  = 7'b0000010;
   localparam logic [6:0] I_CLR  = 7'b0000001;

   typedef struct {
      logic [6:0]  in;
      logic [8:0]  out;
      logic [15:0] s;
      logic [15:0] f;
   } vec_t;

   typedef struct packed {
      logic [8:0]  o;
      logic        chk;
      logic [15:0] s;
      logic [15:0] f;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        ld_hazard, br_taken, mem_req, mem_ready, halt_req, resume, clr_stats;
   logic        pc_enable, ifid_enable, ifid_flush, nop_insertion_s;
   logic        idex_enable, exmem_enable, memwb_nop_s, halted, mem_timeout;
   logic [15:0] stall_cnt, flush_cnt;

   int nvec = 0;
   int nerr = 0;
   exp_t exp_q[$];
   vec_t tbl[25];

   pipe_stall_ctrl #(.CNT_W(16), .MEM_TIMEOUT(15), .DRAIN_CYCLES(3)) u_dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .ld_hazard       (ld_hazard),
      .br_taken        (br_taken),
      .mem_req         (mem_req),
      .mem_ready       (mem_ready),
      .halt_req        (halt_req),
      .resume          (resume),
      .clr_stats       (clr_stats),
      .pc_enable       (pc_enable),
      .ifid_enable     (ifid_enable),
      .ifid_flush      (ifid_flush),
      .nop_insertion_s (nop_insertion_s),
      .idex_enable     (idex_enable),
      .exmem_enable    (exmem_enable),
      .memwb_nop_s     (memwb_nop_s),
      .halted          (halted),
      .mem_timeout     (mem_timeout),
      .stall_cnt       (stall_cnt),
      .flush_cnt       (flush_cnt)
   );

   always #5 clk = ~clk;

   // Drive one cycle of inputs (called at a negedge), record expectation, compare, advance.
   task automatic step(input logic [6:0] in, input logic [8:0] eo, input logic chk,
                       input logic [15:0] es, input logic [15:0] ef, input string nm);
      exp_t e;
      logic [8:0] got;
      {ld_hazard, br_taken, mem_req, mem_ready, halt_req, resume, clr_stats} = in;
      exp_q.push_back('{o: eo, chk: chk, s: es, f: ef});
      #1;
      e = exp_q.pop_front();
      got = {pc_enable, ifid_enable, ifid_flush, nop_insertion_s,
             idex_enable, exmem_enable, memwb_nop_s, halted, mem_timeout};
      nvec++;
      if (got !== e.o) begin
         nerr++;
         $display("FAIL %s ctrl: got %b want %b", nm, got, e.o);
      end
      if (e.chk) begin
         nvec++;
         if ((stall_cnt !== e.s) || (flush_cnt !== e.f)) begin
            nerr++;
            $display("FAIL %s cnt: got stall=%h flush=%h want stall=%h flush=%h",
                     nm, stall_cnt, flush_cnt, e.s, e.f);
         end
      end
      @(negedge clk);
   endtask

   initial begin
      tbl[0]  = '{I_NONE,                           RUNP, 16'd0, 16'd0};
      tbl[1]  = '{I_LD,                             LDP,  16'd0, 16'd0};
      tbl[2]  = '{I_LD | I_BR,                      LDP,  16'd1, 16'd0};
      tbl[3]  = '{I_BR,                             BRP,  16'd2, 16'd0};
      tbl[4]  = '{I_NONE,                           RUNP, 16'd2, 16'd1};
      tbl[5]  = '{I_MREQ | I_MRDY,                  RUNP, 16'd2, 16'd1};
      tbl[6]  = '{I_MREQ | I_LD | I_BR | I_HALT,    FRZ,  16'd2, 16'd1};
      tbl[7]  = '{I_NONE,                           RUNP, 16'd3, 16'd1};
      tbl[8]  = '{I_HALT,                           RUNP, 16'd3, 16'd1};
      tbl[9]  = '{I_HALT,                           DRN,  16'd3, 16'd1};
      tbl[10] = '{I_LD | I_BR,                      DRN,  16'd3, 16'd1};
      tbl[11] = '{I_NONE,                           DRN,  16'd3, 16'd1};
      tbl[12] = '{I_NONE,                           HLT,  16'd3, 16'd1};
      tbl[13] = '{I_BR,                             HLT,  16'd3, 16'd1};
      tbl[14] = '{I_RES | I_HALT,                   HLT,  16'd3, 16'd1};
      tbl[15] = '{I_HALT,                           RUNP, 16'd3, 16'd1};
      tbl[16] = '{I_HALT,                           RUNP, 16'd3, 16'd1};
      tbl[17] = '{I_NONE,                           RUNP, 16'd3, 16'd1};
      tbl[18] = '{I_HALT,                           RUNP, 16'd3, 16'd1};
      tbl[19] = '{I_NONE,                           DRN,  16'd3, 16'd1};
      tbl[20] = '{I_NONE,                           DRN,  16'd3, 16'd1};
      tbl[21] = '{I_NONE,                           DRN,  16'd3, 16'd1};
      tbl[22] = '{I_NONE,                           HLT,  16'd3, 16'd1};
      tbl[23] = '{I_RES,                            HLT,  16'd3, 16'd1};
      tbl[24] = '{I_NONE,                           RUNP, 16'd3, 16'd1};

      // Reset: outputs take the RUN pattern even with a hazard asserted.
      reset_n = 1'b0;
      {ld_hazard, br_taken, mem_req, mem_ready, halt_req, resume, clr_stats} = I_LD;
      @(negedge clk);
      @(negedge clk);
      step(I_LD, RUNP, 1'b1, 16'd0, 16'd0, "reset");
      reset_n = 1'b1;

      for (int i = 0; i < 25; i++) begin
         step(tbl[i].in, tbl[i].out, 1'b1, tbl[i].s, tbl[i].f, $sformatf("tbl[%0d]", i));
      end

      // Memory wait: 16 frozen cycles, timeout from the 16th, then ready.
      step(I_CLR, RUNP, 1'b1, 16'd3, 16'd1, "clr_stats");
      for (int k = 1; k <= 16; k++) begin
         step(I_MREQ, (k >= 16) ? (FRZ | TO) : FRZ, 1'b1, 16'(k - 1), 16'd0,
              $sformatf("freeze[%0d]", k));
      end
      step(I_MREQ | I_MRDY, RUNP | TO, 1'b1, 16'd16, 16'd0, "mem_ready");
      step(I_NONE, RUNP | TO, 1'b1, 16'd16, 16'd0, "after_wait");

      // Freeze inside DRAIN holds the drain counter: halted two cycles late.
      step(I_HALT, RUNP | TO, 1'b0, 16'd0, 16'd0, "dfz_halt");
      step(I_NONE, DRN | TO, 1'b0, 16'd0, 16'd0, "dfz_d0");
      step(I_NONE, DRN | TO, 1'b0, 16'd0, 16'd0, "dfz_d1");
      step(I_MREQ, FRZ | TO, 1'b0, 16'd0, 16'd0, "dfz_f0");
      step(I_MREQ, FRZ | TO, 1'b0, 16'd0, 16'd0, "dfz_f1");
      step(I_NONE, DRN | TO, 1'b0, 16'd0, 16'd0, "dfz_d2");
      step(I_NONE, HLT | TO, 1'b0, 16'd0, 16'd0, "dfz_halted");
      step(I_RES, HLT | TO, 1'b0, 16'd0, 16'd0, "dfz_resume");
      step(I_NONE, RUNP | TO, 1'b0, 16'd0, 16'd0, "dfz_run");

      // Saturation of stall_cnt and clear winning over increment.
      step(I_CLR, RUNP | TO, 1'b0, 16'd0, 16'd0, "sat_clr");
      force u_dut.u_stall_cnt.count = 16'hFFFE;
      #1;
      release u_dut.u_stall_cnt.count;
      step(I_LD, LDP | TO, 1'b1, 16'hFFFE, 16'd0, "sat_fffe");
      step(I_LD, LDP | TO, 1'b1, 16'hFFFF, 16'd0, "sat_ffff");
      step(I_LD, LDP | TO, 1'b1, 16'hFFFF, 16'd0, "sat_hold");
      step(I_LD | I_CLR, LDP | TO, 1'b1, 16'hFFFF, 16'd0, "clr_vs_inc");
      step(I_NONE, RUNP | TO, 1'b1, 16'd0, 16'd0, "clr_won");

      // Reset mid-DRAIN returns to RUN and clears status.
      step(I_HALT, RUNP | TO, 1'b0, 16'd0, 16'd0, "rst_halt");
      step(I_NONE, DRN | TO, 1'b0, 16'd0, 16'd0, "rst_drain");
      reset_n = 1'b0;
      step(I_LD, RUNP | TO, 1'b0, 16'd0, 16'd0, "rst_in_drain");
      reset_n = 1'b1;
      step(I_NONE, RUNP, 1'b1, 16'd0, 16'd0, "rst_run0");
      step(I_NONE, RUNP, 1'b1, 16'd0, 16'd0, "rst_run1");

      // Reset mid-freeze returns to RUN.
      step(I_MREQ, FRZ, 1'b0, 16'd0, 16'd0, "rstf_freeze");
      reset_n = 1'b0;
      step(I_MREQ, RUNP, 1'b0, 16'd0, 16'd0, "rstf_in_reset");
      reset_n = 1'b1;
      step(I_NONE, RUNP, 1'b1, 16'd0, 16'd0, "rstf_run");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
